alu_issue_stage: RTL and testbench

Two-stage operand-issue and writeback stage that sits directly upstream of the 32-bit combinational `ALU`. It accepts register-form or literal-form instructions over a valid/ready handshake and reads operands from a 32-entry register file, forwarding in-flight results where needed. It drives `ALU` inputs `a`, `b` and `fn` from registered state, captures `ALU.out`, writes it back to the register file, and presents it on a result handshake.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_regfile.sv | 48 ++++
 rtl/alu_issue_stage.sv | 178 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue/writeback slice: function codes
// understood by the downstream ALU and the hardwired-zero register index.
package alu_pkg;

  localparam int REG_W  = 5;
  localparam int FN_W   = 6;
  localparam int NUM_RF = 32;

  localparam logic [FN_W-1:0] FN_CMPEQ = 6'b000011;
  localparam logic [FN_W-1:0] FN_CMPLT = 6'b000101;
  localparam logic [FN_W-1:0] FN_CMPLE = 6'b000111;
  localparam logic [FN_W-1:0] FN_ADD   = 6'b010000;
  localparam logic [FN_W-1:0] FN_SUB   = 6'b010001;
  localparam logic [FN_W-1:0] FN_AND   = 6'b101000;
  localparam logic [FN_W-1:0] FN_XOR   = 6'b100110;
  localparam logic [FN_W-1:0] FN_OR    = 6'b101110;
  localparam logic [FN_W-1:0] FN_SHL   = 6'b110000;
  localparam logic [FN_W-1:0] FN_SHR   = 6'b110001;
  localparam logic [FN_W-1:0] FN_SRA   = 6'b110011;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd31;

endpackage

// File: rtl/alu_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous
// write port. Entry 31 always reads as zero and ignores writes.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [4:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [NUM_RF];

  // Storage update: clear everything on reset, otherwise write when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RF; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous reads with R31 forced to zero.
  always_comb begin
    rdata_a_o = {DATA_W{1'b0}};
    rdata_b_o = {DATA_W{1'b0}};
    if (raddr_a_i != REG_ZERO) begin
      rdata_a_o = mem_q[raddr_a_i];
    end else begin
      rdata_a_o = {DATA_W{1'b0}};
    end
    if (raddr_b_i != REG_ZERO) begin
      rdata_b_o = mem_q[raddr_b_i];
    end else begin
      rdata_b_o = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue (EX) and writeback (WB) stage in front of a combinational
// ALU. EX drives the ALU inputs from registers; WB captures the ALU output,
// writes it to the register file and offers it on the result handshake.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LIT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_fn,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_ra,
  input  logic [4:0]        in_rb,
  input  logic [LIT_W-1:0]  in_lit,
  input  logic              in_use_lit,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_fn,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [4:0]        res_rd
);

  // EX stage registers and next-state
  logic              ex_valid_q, ex_valid_d;
  logic [4:0]        ex_rd_q,    ex_rd_d;
  logic [DATA_W-1:0] alu_a_q,    alu_a_d;
  logic [DATA_W-1:0] alu_b_q,    alu_b_d;
  logic [5:0]        alu_fn_q,   alu_fn_d;

  // WB stage registers and next-state
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q,  res_data_d;
  logic [4:0]        res_rd_q,    res_rd_d;

  // Handshake / control
  logic wb_free_s;
  logic ex_adv_s;
  logic accept_s;
  logic fwd_en_s;
  logic rf_we_s;

  // Register-file read data and resolved operands
  logic [DATA_W-1:0] rf_a_s;
  logic [DATA_W-1:0] rf_b_s;
  logic [DATA_W-1:0] opa_s;
  logic [DATA_W-1:0] opb_s;
  logic [DATA_W-1:0] lit_ext_s;

  // Source select: zero register, then bypass of the result retiring this
  // cycle, then the register file. The bypass is the only one needed since
  // the register file is written at the EX-to-WB transfer.
  function automatic logic [DATA_W-1:0] resolve_operand(
    input logic [4:0]        rs,
    input logic [DATA_W-1:0] rf_val,
    input logic              fwd_en,
    input logic [4:0]        fwd_rd,
    input logic [DATA_W-1:0] fwd_val
  );
    logic [DATA_W-1:0] val;
    if (rs == REG_ZERO) begin
      val = {DATA_W{1'b0}};
    end else if (fwd_en && (fwd_rd == rs)) begin
      val = fwd_val;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  alu_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rf_we_s),
    .waddr_i   (ex_rd_q),
    .wdata_i   (alu_out),
    .raddr_a_i (in_ra),
    .rdata_a_o (rf_a_s),
    .raddr_b_i (in_rb),
    .rdata_b_o (rf_b_s)
  );

  // Pipeline advance, accept and register-file write enable.
  always_comb begin
    wb_free_s = !res_valid_q || res_ready;
    ex_adv_s  = ex_valid_q && wb_free_s;
    in_ready  = !rst && (!ex_valid_q || ex_adv_s);
    accept_s  = in_valid && in_ready;
    fwd_en_s  = ex_adv_s && (ex_rd_q != REG_ZERO);
    rf_we_s   = ex_adv_s && (ex_rd_q != REG_ZERO);
  end

  // Operand resolution for both sources; B may take the sign-extended literal.
  always_comb begin
    lit_ext_s = {{(DATA_W-LIT_W){in_lit[LIT_W-1]}}, in_lit};
    opa_s = resolve_operand(in_ra, rf_a_s, fwd_en_s, ex_rd_q, alu_out);
    if (in_use_lit) begin
      opb_s = lit_ext_s;
    end else begin
      opb_s = resolve_operand(in_rb, rf_b_s, fwd_en_s, ex_rd_q, alu_out);
    end
  end

  // EX next-state: load on accept, empty when advancing without refill, else hold.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rd_d    = ex_rd_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_fn_d   = alu_fn_q;
    if (accept_s) begin
      ex_valid_d = 1'b1;
      ex_rd_d    = in_rd;
      alu_a_d    = opa_s;
      alu_b_d    = opb_s;
      alu_fn_d   = in_fn;
    end else if (ex_adv_s) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // WB next-state: capture ALU output on advance, empty on drain, else hold.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    if (ex_adv_s) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_out;
      res_rd_d    = ex_rd_q;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // EX and WB state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= 5'd0;
      alu_a_q     <= {DATA_W{1'b0}};
      alu_b_q     <= {DATA_W{1'b0}};
      alu_fn_q    <= 6'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= {DATA_W{1'b0}};
      res_rd_q    <= 5'd0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fn_q    <= alu_fn_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fn    = alu_fn_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU closing the loop.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_fn;
  logic [4:0]  in_rd;
  logic [4:0]  in_ra;
  logic [4:0]  in_rb;
  logic [15:0] in_lit;
  logic        in_use_lit;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_fn;
  logic [31:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;

  int n_cmp;
  int n_bad;

  alu_issue_stage #(
    .DATA_W (32),
    .LIT_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fn      (in_fn),
    .in_rd      (in_rd),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_lit     (in_lit),
    .in_use_lit (in_use_lit),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fn     (alu_fn),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_rd     (res_rd)
  );

  // Behavioural stand-in for the downstream combinational ALU.
  always_comb begin
    alu_out = 32'd0;
    case (alu_fn)
      FN_ADD:   alu_out = alu_a + alu_b;
      FN_SUB:   alu_out = alu_a - alu_b;
      FN_CMPEQ: alu_out = {31'd0, alu_a == alu_b};
      FN_CMPLT: alu_out = {31'd0, $signed(alu_a) <  $signed(alu_b)};
      FN_CMPLE: alu_out = {31'd0, $signed(alu_a) <= $signed(alu_b)};
      FN_AND:   alu_out = alu_a & alu_b;
      FN_OR:    alu_out = alu_a | alu_b;
      FN_XOR:   alu_out = alu_a ^ alu_b;
      FN_SHL:   alu_out = alu_a << alu_b[4:0];
      FN_SHR:   alu_out = alu_a >> alu_b[4:0];
      FN_SRA:   alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default:  alu_out = 32'd0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] ra,
                       input logic [4:0] rb, input logic [15:0] lit, input logic use_lit);
    in_valid   = 1'b1;
    in_fn      = fn;
    in_rd      = rd;
    in_ra      = ra;
    in_rb      = rb;
    in_lit     = lit;
    in_use_lit = use_lit;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    res_ready = 1'b1;
    issue(FN_ADD, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0);
    idle();

    // Reset state
    tick();
    tick();
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_alu_a",     alu_a,              32'd0);
    check("rst_alu_b",     alu_b,              32'd0);
    check("rst_alu_fn",    {26'd0, alu_fn},    32'd0);
    check("rst_res_data",  res_data,           32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Literal ADD then dependent SUB, back to back
    issue(FN_ADD, 5'd1, 5'd31, 5'd0, 16'd9, 1'b1);
    tick();
    check("add_alu_a",  alu_a,           32'd0);
    check("add_alu_b",  alu_b,           32'd9);
    check("add_alu_fn", {26'd0, alu_fn}, {26'd0, FN_ADD});
    issue(FN_SUB, 5'd2, 5'd1, 5'd0, 16'd13, 1'b1);
    tick();
    check("add_res_valid", {31'd0, res_valid}, 32'd1);
    check("add_res_data",  res_data,           32'd9);
    check("add_res_rd",    {27'd0, res_rd},    32'd1);
    check("sub_fwd_alu_a", alu_a,              32'd9);
    idle();
    tick();
    check("sub_res_valid", {31'd0, res_valid}, 32'd1);
    check("sub_res_data",  res_data,           32'hFFFF_FFFC);
    check("sub_res_rd",    {27'd0, res_rd},    32'd2);
    tick();
    check("drain_res_valid", {31'd0, res_valid}, 32'd0);

    // Literal sign extension
    issue(FN_ADD, 5'd6, 5'd31, 5'd0, 16'hFFF1, 1'b1);
    tick();
    check("sext_alu_b", alu_b, 32'hFFFF_FFF1);
    idle();
    tick();
    check("sext_res_data", res_data, 32'hFFFF_FFF1);
    tick();

    // R31: write discarded, result still presented
    issue(FN_ADD, 5'd31, 5'd31, 5'd0, 16'd5, 1'b1);
    tick();
    issue(FN_ADD, 5'd7, 5'd31, 5'd0, 16'd0, 1'b1);
    tick();
    check("r31_res_data", res_data,        32'd5);
    check("r31_res_rd",   {27'd0, res_rd}, 32'd31);
    check("r31_rd_alu_a", alu_a,           32'd0);
    idle();
    tick();
    check("r31_rd_res_data", res_data,        32'd0);
    check("r31_rd_res_rd",   {27'd0, res_rd}, 32'd7);
    tick();

    // Backpressure: three instructions with res_ready low
    res_ready = 1'b0;
    issue(FN_ADD, 5'd8, 5'd31, 5'd0, 16'd100, 1'b1);
    tick();
    check("bp_ready_2nd", {31'd0, in_ready}, 32'd1);
    issue(FN_ADD, 5'd9, 5'd31, 5'd0, 16'd200, 1'b1);
    tick();
    check("bp_ready_3rd", {31'd0, in_ready}, 32'd0);
    issue(FN_ADD, 5'd10, 5'd8, 5'd0, 16'd1, 1'b1);
    tick();
    check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_data",  res_data,          32'd100);
    check("bp_hold_alu_b", alu_b,             32'd200);
    tick();
    check("bp_hold2_data",  res_data, 32'd100);
    check("bp_hold2_alu_b", alu_b,    32'd200);
    check("bp_hold2_valid", {31'd0, res_valid}, 32'd1);
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_r2_data",  res_data,        32'd200);
    check("bp_r2_rd",    {27'd0, res_rd}, 32'd9);
    check("bp_i3_alu_a", alu_a,           32'd100);
    idle();
    tick();
    check("bp_r3_data", res_data,        32'd101);
    check("bp_r3_rd",   {27'd0, res_rd}, 32'd10);
    tick();
    check("bp_empty", {31'd0, res_valid}, 32'd0);

    // Compare right after writing the second operand (forwarded)
    issue(FN_ADD, 5'd3, 5'd31, 5'd0, 16'd11, 1'b1);
    tick();
    issue(FN_ADD, 5'd4, 5'd31, 5'd0, 16'd13, 1'b1);
    tick();
    issue(FN_CMPLE, 5'd5, 5'd3, 5'd4, 16'd0, 1'b0);
    tick();
    check("cmp_alu_a",  alu_a,           32'd11);
    check("cmp_alu_b",  alu_b,           32'd13);
    check("cmp_alu_fn", {26'd0, alu_fn}, {26'd0, FN_CMPLE});
    idle();
    tick();
    check("cmp_res_data", res_data,        32'd1);
    check("cmp_res_rd",   {27'd0, res_rd}, 32'd5);
    tick();

    // Reset with EX and WB both full
    res_ready = 1'b0;
    issue(FN_ADD, 5'd11, 5'd31, 5'd0, 16'd77, 1'b1);
    tick();
    issue(FN_ADD, 5'd1, 5'd31, 5'd0, 16'd88, 1'b1);
    tick();
    check("mid_full_valid", {31'd0, res_valid}, 32'd1);
    check("mid_full_ready", {31'd0, in_ready},  32'd0);
    idle();
    rst = 1'b1;
    tick();
    check("mid_rst_valid",  {31'd0, res_valid}, 32'd0);
    check("mid_rst_data",   res_data,           32'd0);
    check("mid_rst_rd",     {27'd0, res_rd},    32'd0);
    check("mid_rst_alu_a",  alu_a,              32'd0);
    check("mid_rst_alu_b",  alu_b,              32'd0);
    check("mid_rst_alu_fn", {26'd0, alu_fn},    32'd0);
    check("mid_rst_ready",  {31'd0, in_ready},  32'd0);
    rst = 1'b0;
    res_ready = 1'b1;
    issue(FN_ADD, 5'd13, 5'd1, 5'd0, 16'd0, 1'b1);
    tick();
    check("post_rst_no_ghost", {31'd0, res_valid}, 32'd0);
    check("post_rst_r1_alu_a", alu_a,              32'd0);
    idle();
    tick();
    check("post_rst_r1_data", res_data,        32'd0);
    check("post_rst_r1_rd",   {27'd0, res_rd}, 32'd13);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
